// File: rtl/memory_128x8.sv
// Single-port 128 x 8 synchronous RAM with a registered read port.
// Reads return the old word when the same address is written in that cycle.
module memory_128x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  wr_en,
    input  logic                  rd_en
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Read samples mem_q, so a same-cycle write is not yet visible.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[addr];
        end
        if (wr_en) begin
            mem_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_memory_128x8.sv
// Directed bench for memory_128x8.
// Expected values are constants or a bench-side copy of written data.
module tb_memory_128x8;

    logic       clk;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       wr_en;
    logic       rd_en;

    int checks;
    int errors;

    logic [7:0] vals [128];

    memory_128x8 dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .wr_en (wr_en),
        .rd_en (rd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (rdata === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, rdata, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r,
                         input logic [6:0] a, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b0, 1'b0, 7'd0, 8'd0);

        // Reset clear
        step();
        step();
        check("reset_rdata", 8'h00);
        rst = 1'b1;
        drive(1'b0, 1'b1, 7'd0, 8'd0);
        step();
        check("reset_a0", 8'h00);
        drive(1'b0, 1'b1, 7'd64, 8'd0);
        step();
        check("reset_a64", 8'h00);
        drive(1'b0, 1'b1, 7'd127, 8'd0);
        step();
        check("reset_a127", 8'h00);

        // Full sweep
        for (int i = 0; i < 128; i++) begin
            vals[i] = 8'($urandom_range(0, 255));
            drive(1'b1, 1'b0, 7'(i), vals[i]);
            step();
        end
        for (int i = 0; i < 128; i++) begin
            drive(1'b0, 1'b1, 7'(i), 8'h00);
            step();
            check($sformatf("sweep_a%0d", i), vals[i]);
        end

        // Hold behaviour
        drive(1'b1, 1'b0, 7'd5, 8'hA5);
        step();
        drive(1'b1, 1'b0, 7'd6, 8'h3C);
        step();
        drive(1'b0, 1'b1, 7'd5, 8'h00);
        step();
        check("hold_read5", 8'hA5);
        drive(1'b0, 1'b0, 7'd6, 8'h00);
        step();
        check("hold_1", 8'hA5);
        step();
        check("hold_2", 8'hA5);

        // Read-during-write
        drive(1'b1, 1'b0, 7'd10, 8'h11);
        step();
        drive(1'b1, 1'b1, 7'd10, 8'h22);
        step();
        check("rdw_old", 8'h11);
        drive(1'b0, 1'b1, 7'd10, 8'h00);
        step();
        check("rdw_new", 8'h22);

        // Reset mid-operation; rdata is nonzero before the reset edge
        drive(1'b1, 1'b0, 7'd3, 8'h5A);
        step();
        drive(1'b0, 1'b1, 7'd3, 8'h00);
        step();
        check("pre_reset_a3", 8'h5A);
        rst = 1'b0;
        drive(1'b1, 1'b1, 7'd4, 8'h77);
        step();
        check("mid_reset_rdata", 8'h00);
        rst = 1'b1;
        drive(1'b0, 1'b1, 7'd3, 8'h00);
        step();
        check("post_reset_a3", 8'h00);
        drive(1'b0, 1'b1, 7'd4, 8'h00);
        step();
        check("post_reset_a4", 8'h00);
        drive(1'b0, 1'b1, 7'd10, 8'h00);
        step();
        check("post_reset_a10", 8'h00);

        // Disabled write
        drive(1'b0, 1'b0, 7'd20, 8'hFF);
        step();
        drive(1'b0, 1'b1, 7'd20, 8'h00);
        step();
        check("nowrite_a20", 8'h00);

        // Back-to-back write then read of a fresh value
        drive(1'b1, 1'b0, 7'd127, 8'hC3);
        step();
        drive(1'b0, 1'b1, 7'd127, 8'h00);
        step();
        check("b2b_a127", 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_128x8.md
# memory_128x8

Single-port, synchronous 128 x 8 random-access memory with independent write and read enables and a registered read port. Serves as a general-purpose on-chip scratch storage block; all accesses are on the rising clock edge. A synchronous reset clears every storage location and the read register.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each word and of wdata/rdata
- ADDR_WIDTH, 7, address width
- DEPTH, 128 (2**ADDR_WIDTH), number of words

Ports (positional order: clk, rst, addr, wdata, rdata, wr_en, rd_en):
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  one clock; reset is synchronous and active-low (rst = 0 resets on the next rising clk edge)
- addr  input  ADDR_WIDTH  word address shared by read and write
- wdata  input  DATA_WIDTH  write data
- rdata  output  DATA_WIDTH  registered read data
- wr_en  input  1  write enable, active-high
- rd_en  input  1  read enable, active-high

## Operation
- Storage: DEPTH words of DATA_WIDTH bits.
- Reset (rst = 0 at a rising edge):
  - all DEPTH words become 0
  - rdata becomes 0
  - wr_en and rd_en are ignored in that cycle
  - reset has priority over every other operation
- Write (rst = 1, wr_en = 1): mem[addr] <= wdata at the rising edge.
- Read (rst = 1, rd_en = 1): rdata <= mem[addr] at the rising edge.
- Read with rd_en = 0: rdata holds its previous value.
- Write with wr_en = 0: memory unchanged.
- Simultaneous wr_en = 1 and rd_en = 1 at the same addr:
  - read-before-write
  - rdata receives the old contents
  - the new value is stored and is visible to the next read
- Simultaneous read and write at different addresses is impossible because addr is shared; the single addr applies to both.
- All addresses 0..DEPTH-1 are valid; there is no out-of-range case.
- No X propagation after reset: every word is defined.

## Timing
- Write latency: data is written at edge N, where wr_en, addr and wdata are sampled. A read issued at edge N+1 returns it.
- Read latency: one cycle. rd_en and addr are sampled at edge N; rdata is valid after edge N and stable until the next edge that performs a read or reset.
- Reset mid-operation: an operation sampled in the same cycle as rst = 0 is discarded. Contents written before reset are lost (read back as 0).
- Release: the first rising edge with rst = 1 performs normal operations.
- No handshake, no wait states; back-to-back reads and writes are accepted every cycle.

## Test plan
- Reset clear: hold rst = 0 for 2 cycles, then read addr 0, 64 and 127 -> rdata = 0x00 each, one cycle after each read.
- Full sweep: write mem[i] = pseudo-random values for i = 0..127 on consecutive cycles, then read i = 0..127 on consecutive cycles -> rdata equals the written value for each address, one cycle after the address is presented.
- Hold behaviour: read addr 5 (value 0xA5), then drop rd_en and change addr to 6 -> rdata stays 0xA5.
- Read-during-write: mem[10] = 0x11; in one cycle drive wr_en = 1, rd_en = 1, addr = 10, wdata = 0x22 -> rdata = 0x11. Next-cycle read of addr 10 -> rdata = 0x22.
- Disabled write: drive wr_en = 0 with addr = 20 and wdata = 0xFF, then read addr 20 -> rdata equals the prior contents (0x00 after reset).
- Reset mid-operation: write 0x5A to addr 3, assert rst = 0 for one cycle together with wr_en = 1, addr = 4, wdata = 0x77, then read addr 3 and addr 4 -> both return 0x00; rdata = 0x00 immediately after the reset edge.
